// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared state encoding and constants for the instruction-fetch stage.
// Revision 1.0
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } fetch_state_e;

  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;
  localparam int         PC_INCR          = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: reads one instruction word at the latched PC, then pulses pc_ena/done once.
// Revision 1.0
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc,
  input  logic         start,
  output logic [N-1:0] mem_addr,
  output logic         mem_rd,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [W-1:0] instr,
  output logic [N-1:0] pc_plus4,
  output logic         pc_ena,
  output logic         done,
  output logic         busy,
  output logic         fault
);

  fetch_state_e state_q, state_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0] pc_plus4_q, pc_plus4_d;
  logic [W-1:0] instr_q, instr_d;
  logic         fault_q, fault_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((pc[1:0] & INSTR_ALIGN_MASK) == 2'b00) begin
            mem_addr_d = pc;
            // Modulo-2^N add: the top address wraps to zero.
            pc_plus4_d = pc + N'(PC_INCR);
            fault_d    = 1'b0;
            state_d    = S_REQ;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
  assign mem_rd   = (state_q == S_REQ);
  assign pc_ena   = (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign mem_addr = mem_addr_q;
  assign pc_plus4 = pc_plus4_q;
  assign instr    = instr_q;
  assign fault    = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard-based bench for the instruction-fetch stage.
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        start = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        pc_ena;
  logic        done;
  logic        busy;
  logic        fault;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pe_cnt = 0;
  logic [31:0] exp_instr = '0;

  fetch_unit #(.N(32), .W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr(instr), .pc_plus4(pc_plus4), .pc_ena(pc_ena), .done(done),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pc_ena === 1'b1) pe_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] w);
    exp_t x;
    x.addr = a;
    x.word = w;
    x.pc4  = a + 32'd4;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    pc = $urandom; start = 1'($urandom_range(0, 1));
    mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_rd, pc_ena, done, busy, fault} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_rd, pc_ena, done, busy, fault});
    end
    n_checks++;
    if ({instr, mem_addr, pc_plus4} !== 96'b0) begin
      n_fail++; $display("FAIL reset_data: instr=%h addr=%h pc4=%h want 0", instr, mem_addr, pc_plus4);
    end
    start = 1'b0; mem_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b mem_rd=%b want 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_zero_wait();
    pc = 32'h0040_0000; start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h2008_000A;
    push_exp(pc, mem_rdata);
    step();
    start = 1'b0;
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== sb[0].addr || done !== 1'b0) begin
      n_fail++; $display("FAIL zw_req: mem_rd=%b addr=%h done=%b want 1 %h 0", mem_rd, mem_addr, done, sb[0].addr);
    end
    step();
    mem_rdata = 32'hDEAD_BEEF;
    n_checks++;
    if (done !== 1'b1 || pc_ena !== 1'b1 || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL zw_done: done=%b pc_ena=%b mem_rd=%b want 1 1 0", done, pc_ena, mem_rd);
    end else begin
      e = sb.pop_front();
      exp_instr = e.word;
      n_checks++;
      if (instr !== e.word || pc_plus4 !== e.pc4) begin
        n_fail++; $display("FAIL zw_data: instr=%h pc4=%h want %h %h", instr, pc_plus4, e.word, e.pc4);
      end
    end
    step();
    n_checks++;
    if (done !== 1'b0 || pc_ena !== 1'b0 || busy !== 1'b0 || instr !== exp_instr) begin
      n_fail++; $display("FAIL zw_after: done=%b pc_ena=%b busy=%b instr=%h want 0 0 0 %h",
                         done, pc_ena, busy, instr, exp_instr);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_wait_states();
    int pe0;
    logic seen_done;
    pe0 = pe_cnt;
    seen_done = 1'b0;
    pc = 32'h0040_0000; start = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h1111_2222;
    push_exp(pc, 32'h8C08_0010);
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (mem_rd !== 1'b1 || mem_addr !== sb[0].addr || done !== 1'b0) begin
        n_fail++; $display("FAIL ws_req%0d: mem_rd=%b addr=%h done=%b want 1 %h 0", i, mem_rd, mem_addr, done, sb[0].addr);
      end
      if (i == 2) begin start = 1'b1; pc = 32'h0040_0100; end
      if (i == 3) start = 1'b0;
      if (i == 4) begin mem_ready = 1'b1; mem_rdata = 32'h8C08_0010; end
      step();
    end
    mem_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1 || pc_ena !== 1'b1) begin
      n_fail++; $display("FAIL ws_done: done=%b pc_ena=%b want 1 1", done, pc_ena);
    end else begin
      seen_done = 1'b1;
      e = sb.pop_front();
      exp_instr = e.word;
      n_checks++;
      if (instr !== e.word || pc_plus4 !== e.pc4) begin
        n_fail++; $display("FAIL ws_data: instr=%h pc4=%h want %h %h", instr, pc_plus4, e.word, e.pc4);
      end
    end
    if (!seen_done && sb.size() != 0) void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (mem_rd !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL ws_nosecond: mem_rd=%b busy=%b want 0 0", mem_rd, busy);
      end
    end
    n_checks++;
    if (pe_cnt - pe0 != 1) begin
      n_fail++; $display("FAIL ws_pcena_count: got %0d want 1", pe_cnt - pe0);
    end
  endtask

  task automatic test_misaligned();
    pc = 32'h0040_0002; start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    start = 1'b0;
    n_checks++;
    if (fault !== 1'b1 || mem_rd !== 1'b0 || done !== 1'b0 || pc_ena !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mis_fault: fault=%b mem_rd=%b done=%b pc_ena=%b busy=%b want 1 0 0 0 0",
                         fault, mem_rd, done, pc_ena, busy);
    end
    step();
    n_checks++;
    if (fault !== 1'b1 || mem_rd !== 1'b0 || pc_ena !== 1'b0 || instr !== exp_instr) begin
      n_fail++; $display("FAIL mis_hold: fault=%b mem_rd=%b pc_ena=%b instr=%h want 1 0 0 %h",
                         fault, mem_rd, pc_ena, instr, exp_instr);
    end
    pc = 32'h0040_0010; start = 1'b1; mem_rdata = 32'h8C09_0004;
    push_exp(pc, mem_rdata);
    step();
    start = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== sb[0].addr) begin
      n_fail++; $display("FAIL mis_clear: fault=%b mem_rd=%b addr=%h want 0 1 %h", fault, mem_rd, mem_addr, sb[0].addr);
    end
    step();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL mis_done: done=%b want 1", done);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      exp_instr = e.word;
      n_checks++;
      if (instr !== e.word || pc_plus4 !== e.pc4) begin
        n_fail++; $display("FAIL mis_data: instr=%h pc4=%h want %h %h", instr, pc_plus4, e.word, e.pc4);
      end
    end
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    pc = 32'hFFFF_FFFC; start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    push_exp(pc, mem_rdata);
    step();
    start = 1'b0;
    step();
    n_checks++;
    if (pc_ena !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pcena: pc_ena=%b want 1", pc_ena);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      exp_instr = e.word;
      n_checks++;
      if (pc_plus4 !== e.pc4 || pc_plus4 !== 32'h0 || instr !== e.word) begin
        n_fail++; $display("FAIL wrap_pc4: pc4=%h instr=%h want %h %h", pc_plus4, instr, e.pc4, e.word);
      end
    end
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    pc = 32'h0040_0004; start = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h5555_AAAA;
    push_exp(pc, mem_rdata);
    step();
    start = 1'b0;
    n_checks++;
    if (mem_rd !== 1'b1) begin
      n_fail++; $display("FAIL rm_req: mem_rd=%b want 1", mem_rd);
    end
    #2 rst = 1'b1;
    #1;
    void'(sb.pop_front());
    exp_instr = '0;
    n_checks++;
    if (mem_rd !== 1'b0 || busy !== 1'b0 || instr !== exp_instr || mem_addr !== 32'h0 || pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL rm_async: mem_rd=%b busy=%b instr=%h addr=%h pc4=%h want 0 0 0 0 0",
                         mem_rd, busy, instr, mem_addr, pc_plus4);
    end
    step();
    rst = 1'b0;
    step();
    pc = 32'h0040_0008; start = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0128_4020;
    push_exp(pc, mem_rdata);
    step();
    start = 1'b0;
    n_checks++;
    if (mem_rd !== 1'b1 || mem_addr !== sb[0].addr) begin
      n_fail++; $display("FAIL rm_req2: mem_rd=%b addr=%h want 1 %h", mem_rd, mem_addr, sb[0].addr);
    end
    step();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL rm_done: done=%b want 1", done);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (pc_plus4 !== e.pc4 || pc_plus4 !== 32'h0040_000C || instr !== e.word) begin
        n_fail++; $display("FAIL rm_data: pc4=%h instr=%h want %h %h", pc_plus4, instr, e.pc4, e.word);
      end
    end
    mem_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, runs a read transaction on instruction memory with a ready handshake, and latches the returned word into an instruction register.
- Returns PC+4 and a one-cycle enable pulse so the PC register advances exactly once per completed fetch.
- Driven by the multicycle control FSM through a start/done handshake.

Parameters:
- N, 32, address/PC width
- W, 32, instruction word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc  in  N  current PC (PC register q output)
- start  in  1  control FSM requests one fetch; sampled only in IDLE
- mem_addr  out  N  instruction memory address
- mem_rd  out  1  memory read request; held until accepted
- mem_rdata  in  W  memory read data; valid when mem_ready=1
- mem_ready  in  1  memory accepts read and presents data this cycle
- instr  out  W  instruction register
- pc_plus4  out  N  latched fetch address + 4; drives PC register d
- pc_ena  out  1  one-cycle pulse; drives PC register ena
- done  out  1  one-cycle pulse; fetch complete, instr valid
- busy  out  1  high in any state other than IDLE
- fault  out  1  sticky misaligned-PC flag

Behaviour:
- Reset (async, active-high) takes effect immediately, including mid-transaction.
  - State returns to IDLE.
  - mem_rd, pc_ena, done, busy and fault go to 0.
  - instr, mem_addr and pc_plus4 go to 0.
- All outputs are registers or decodes of the state register; no combinational path from any input to any output.
- States and transitions:
  - IDLE
    - start=1 and pc[1:0]==0: latch mem_addr<=pc, pc_plus4<=pc+4, clear fault, go to REQ.
    - start=1 and pc[1:0]!=0: set fault=1, stay in IDLE; no memory access, no pc_ena.
    - start=0: hold.
  - REQ
    - mem_rd=1; mem_addr is stable for the whole state.
    - mem_ready=1: instr<=mem_rdata, go to DONE.
    - mem_ready=0: stay in REQ. Wait states are unbounded.
  - DONE
    - pc_ena=1 and done=1 for exactly one cycle; mem_rd=0.
    - Unconditionally go to IDLE.
- Latency:
  - start sampled at edge 0; REQ occupies cycle 1.
  - With mem_ready high in cycle 1, DONE occupies cycle 2 and the PC register loads pc_plus4 at the end of cycle 2.
  - Minimum is 3 cycles start-to-start. Each wait state adds 1.
- start while busy=1 is ignored and is not queued.
- pc changing after the start edge has no effect; only the latched address is used.
- fault is cleared only by the next aligned start or by rst.
- pc_plus4 is computed modulo 2^N: 0xFFFFFFFC wraps to 0x00000000.
- instr keeps its value until the next successful fetch. A faulted start does not modify it.
- mem_rdata is ignored whenever mem_ready=0 or state!=REQ.

Decomposition:
- Shared package:
  - state enum (IDLE, REQ, DONE), 2-bit encoding
  - INSTR_ALIGN_MASK = 2'b11
  - PC_INCR = 4
- No sub-module: a single FSM plus datapath registers. The PC+4 adder is inline.

Test Plan:
1. Reset: rst=1 with random inputs -> every output 0 in the same cycle (async); rst deasserted -> state IDLE, busy=0.
2. Zero-wait fetch: pc=0x00400000, start for 1 cycle, mem_ready=1 with mem_rdata=0x2008000A -> mem_rd=1 in cycle 1 with mem_addr=0x00400000; cycle 2: instr=0x2008000A, pc_plus4=0x00400004, pc_ena=done=1 for exactly one cycle.
3. Wait states plus busy start: mem_ready held low 3 cycles, start re-pulsed and pc changed to 0x00400100 meanwhile -> mem_rd and mem_addr=0x00400000 stable for 4 cycles; done in cycle 5; exactly one pc_ena; no second fetch.
4. Misaligned PC: pc=0x00400002, start -> fault=1 next cycle; mem_rd, pc_ena and done stay 0; instr unchanged. A following aligned start clears fault.
5. Wrap-around: pc=0xFFFFFFFC fetch -> pc_plus4=0x00000000 with the pc_ena pulse.
6. Reset mid-transaction: rst asserted in REQ -> mem_rd drops asynchronously and instr=0; after release, a start with pc=0x00400008 completes normally with pc_plus4=0x0040000C.
